// File: rtl/mcp3201_pkg.sv
// Shared types and edge-count constants for the MCP3201 ADC emulator.
package mcp3201_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQ,
    MSB,
    LSB,
    TAIL
  } state_t;

  localparam logic [4:0] NULL_EDGE     = 5'd2;
  localparam logic [4:0] MSB_LAST_EDGE = 5'd14;
  localparam logic [4:0] LSB_LAST_EDGE = 5'd25;
  localparam logic [4:0] K_MAX         = 5'd31;

  typedef logic [11:0] sample_t;

endpackage

// File: rtl/mcp3201_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, plus a transition flag
// taken against one further registered copy of the synchronized level.
module mcp3201_pin_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign edge_o  = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/mcp3201_emu.sv
// MCP3201 12-bit SPI ADC emulator: serves a user-loaded sample to an SPI master.
// Define MCP3201_LSB_TAIL_EN to enable the LSB-first retransmission after B0.
module mcp3201_emu
  import mcp3201_pkg::*;
#(
  parameter int      SYNC_STAGES  = 2,
  parameter sample_t RESET_SAMPLE = 12'h000
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample_in,
  input  logic    sample_load,
  output logic    sample_req,
  output logic    frame_done,
  output logic    frame_abort,
  output logic    busy,
  input  logic    cs_pin_n,
  input  logic    clk_pin,
  output logic    data_out_pin,
  output logic    data_oe
);

  logic cs_level, cs_edge, sclk_level, sclk_edge;
  logic cs_fall, cs_rise, sclk_fall;

  mcp3201_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .pin_i(cs_pin_n), .level_o(cs_level), .edge_o(cs_edge)
  );

  mcp3201_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .pin_i(clk_pin), .level_o(sclk_level), .edge_o(sclk_edge)
  );

  assign cs_fall   = cs_edge & ~cs_level;
  assign cs_rise   = cs_edge &  cs_level;
  assign sclk_fall = sclk_edge & ~sclk_level;

  state_t     state_q;
  logic [4:0] k_q, k_inc;
  sample_t    hold_q, shreg_q;
  logic       dout_q, oe_q, req_q, done_q, abort_q;
  logic [3:0] msb_idx;

  // k counts SCLK falls and sticks at K_MAX so long frames never re-enter ACQ.
  assign k_inc   = (k_q == K_MAX) ? K_MAX : 5'(k_q + 5'd1);
  assign msb_idx = 4'(MSB_LAST_EDGE - k_inc);
`ifdef MCP3201_LSB_TAIL_EN
  logic [3:0] lsb_idx;
  assign lsb_idx = 4'(k_inc - MSB_LAST_EDGE);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      hold_q  <= RESET_SAMPLE;
      shreg_q <= '0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (sample_load) hold_q <= sample_in;
      // A CS rise outranks everything, including a simultaneous CS fall.
      if (cs_rise) begin
        if (state_q != IDLE) begin
          oe_q    <= 1'b0;
          dout_q  <= 1'b0;
          done_q  <= (k_q >= MSB_LAST_EDGE);
          abort_q <= (k_q <  MSB_LAST_EDGE);
          state_q <= IDLE;
        end
      end else if (cs_fall) begin
        if (state_q == IDLE) begin
          shreg_q <= hold_q;
          req_q   <= 1'b1;
          k_q     <= '0;
          state_q <= ACQ;
        end
      end else if (sclk_fall && state_q != IDLE) begin
        k_q <= k_inc;
        if (k_inc < NULL_EDGE) begin
          state_q <= ACQ;
          oe_q    <= 1'b0;
        end else if (k_inc == NULL_EDGE) begin
          state_q <= MSB;
          oe_q    <= 1'b1;
          dout_q  <= 1'b0;
        end else if (k_inc <= MSB_LAST_EDGE) begin
          dout_q  <= shreg_q[msb_idx];
`ifdef MCP3201_LSB_TAIL_EN
        end else if (k_inc <= LSB_LAST_EDGE) begin
          state_q <= LSB;
          dout_q  <= shreg_q[lsb_idx];
`endif
        end else begin
          state_q <= TAIL;
          dout_q  <= 1'b0;
        end
      end
    end
  end

  assign sample_req   = req_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign busy         = ~cs_level;
  assign data_out_pin = dout_q;
  assign data_oe      = oe_q;

endmodule
